// File: rtl/alu_seq.sv
// Registered ALU with an iterative multiply/divide engine that owns HI/LO.
// Single-cycle ops complete at acceptance; MULT/DIV run WIDTH iterations behind busy_out.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [3:0]       ALUOp_in,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    output logic [WIDTH-1:0] data_out,
    output logic             done_out,
    output logic             busy_out,
    output logic             ovf_out,
    output logic             div0_out
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_MFHI = 4'd3;
    localparam logic [3:0] OP_MFLO = 4'd4;
    localparam logic [3:0] OP_MULT = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;
    localparam logic [3:0] OP_MTHI = 4'd9;
    localparam logic [3:0] OP_MTLO = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd12;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] single_res;

    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_MFHI: r = hi;
            OP_MFLO: r = lo;
            OP_SUB:  r = a - b;
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MTHI: r = a;
            OP_MTLO: r = a;
            OP_NOR:  r = ~(a | b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Signed overflow: operands (B inverted for SUB) agree in sign but the result does not.
    function automatic logic add_sub_ovf(
        input logic             sub,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] r
    );
        logic b_sign;
        b_sign = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        return (a[WIDTH-1] == b_sign) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    always_comb begin
        // acc/sh hold {HI,LO}-in-progress: multiplier/quotient shifts through sh, partial product/remainder in acc.
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
        single_res = alu_single(ALUOp_in, data1_in, data2_in, hi_q, lo_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        data_d   = data_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        div0_d   = div0_q;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    ovf_d  = 1'b0;
                    div0_d = 1'b0;
                    if (ALUOp_in == OP_MULT || ALUOp_in == OP_DIV) begin
                        state_d  = S_RUN;
                        cnt_d    = CNT_W'(WIDTH - 1);
                        is_div_d = (ALUOp_in == OP_DIV);
                        opb_d    = data2_in;
                        acc_d    = '0;
                        sh_d     = data1_in;
                    end else begin
                        data_d = single_res;
                        done_d = 1'b1;
                        if (ALUOp_in == OP_ADD || ALUOp_in == OP_SUB) begin
                            ovf_d = add_sub_ovf(ALUOp_in == OP_SUB, data1_in, data2_in, single_res);
                        end
                        if (ALUOp_in == OP_MTHI) begin
                            hi_d = data1_in;
                        end
                        if (ALUOp_in == OP_MTLO) begin
                            lo_d = data1_in;
                        end
                    end
                end
            end
            default: begin
                acc_d = step_hi;
                sh_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    data_d  = step_lo;
                    done_d  = 1'b1;
                    div0_d  = is_div_q && (opb_q == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
        end
    end

    assign data_out = data_q;
    assign done_out = done_q;
    assign busy_out = (state_q == S_RUN);
    assign ovf_out  = ovf_q;
    assign div0_out = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit instance driven through a reference model
// plus an 8-bit instance for the narrow multiply case.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic [31:0] dout;
    logic        done, busy, ovf, div0;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic [7:0]  dout8;
    logic        done8, busy8, ovf8, div08;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic        div0;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mhi, mlo;
    int          checks = 0;
    int          errors = 0;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .ALUOp_in(op),
        .data1_in(d1), .data2_in(d2), .data_out(dout), .done_out(done),
        .busy_out(busy), .ovf_out(ovf), .div0_out(div0)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start8), .ALUOp_in(op8),
        .data1_in(a8), .data2_in(b8), .data_out(dout8), .done_out(done8),
        .busy_out(busy8), .ovf_out(ovf8), .div0_out(div08)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: computes the expected completion and tracks HI/LO in issue order.
    task automatic push_exp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        logic [63:0] p;
        e.tag = tag; e.data = '0; e.ovf = 1'b0; e.div0 = 1'b0;
        case (o)
            4'd0:  e.data = a & b;
            4'd1:  e.data = a | b;
            4'd2:  begin e.data = a + b; e.ovf = (a[31] == b[31]) && (e.data[31] != a[31]); end
            4'd3:  e.data = mhi;
            4'd4:  e.data = mlo;
            4'd5:  begin p = {32'b0, a} * {32'b0, b}; mhi = p[63:32]; mlo = p[31:0]; e.data = mlo; end
            4'd6:  begin e.data = a - b; e.ovf = (a[31] != b[31]) && (e.data[31] != a[31]); end
            4'd7:  e.data = (a < b) ? 32'd1 : 32'd0;
            4'd8:  begin
                       if (b == 0) begin mlo = 32'hFFFF_FFFF; mhi = a; e.div0 = 1'b1; end
                       else begin mlo = a / b; mhi = a % b; end
                       e.data = mlo;
                   end
            4'd9:  begin mhi = a; e.data = a; end
            4'd10: begin mlo = a; e.data = a; end
            4'd12: e.data = ~(a | b);
            default: e.data = '0;
        endcase
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("done_unexpected", {63'b0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_data"}, {32'b0, dout}, {32'b0, e.data});
                check_eq({e.tag, "_ovf"}, {63'b0, ovf}, {63'b0, e.ovf});
                check_eq({e.tag, "_div0"}, {63'b0, div0}, {63'b0, e.div0});
            end
        end
    end

    task automatic drive_now(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input string tag, input bit push);
        start = 1'b1; op = o; d1 = a; d2 = b;
        if (push) push_exp(o, a, b, tag);
    endtask

    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        drive_now(o, a, b, tag, 1'b1);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    // Issues a MULT/DIV and returns on the negedge where done_out is seen.
    task automatic run_long(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input string tag, input bit poke);
        int  busy_n;
        bit  seen;
        busy_n = 0; seen = 1'b0;
        send(o, a, b, tag);
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke && k == 5) begin start = 1'b1; op = 4'd2; d1 = 32'd1; d2 = 32'd1; end
            if (poke && k == 6) start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        check_eq({tag, "_seen"}, {63'b0, seen}, 64'd1);
        check_eq({tag, "_busy_cycles"}, busy_n, 64'd32);
        check_eq({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int busy8_n;
        bit seen8;
        rst_n = 1'b0; start = 1'b0; op = '0; d1 = '0; d2 = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        mhi = '0; mlo = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", {32'b0, dout}, 64'd0);
        check_eq("rst_done", {63'b0, done}, 64'd0);
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_ovf", {63'b0, ovf}, 64'd0);
        check_eq("rst_div0", {63'b0, div0}, 64'd0);
        rst_n = 1'b1;

        send(4'd2, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        release_start();
        @(negedge clk);
        check_eq("done_pulse", {63'b0, done}, 64'd0);

        send(4'd6, 32'd5, 32'd3, "sub");
        send(4'd7, 32'd3, 32'd5, "sltu_lt");
        send(4'd7, 32'd5, 32'd3, "sltu_ge");
        send(4'd6, 32'h8000_0000, 32'd1, "sub_ovf");
        send(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
        send(4'd1, 32'hF000_0001, 32'h0000_0F10, "or");
        send(4'd12, 32'h00FF_00FF, 32'h0F00_0F00, "nor");
        send(4'd11, 32'h1234_5678, 32'h1, "undef_op");
        release_start();
        repeat (2) @(negedge clk);

        run_long(4'd5, 32'hFFFF_FFFF, 32'd2, "mult", 1'b0);
        drive_now(4'd3, 32'd0, 32'd0, "mfhi_mult", 1'b1);
        send(4'd4, 32'd0, 32'd0, "mflo_mult");
        release_start();

        run_long(4'd8, 32'd100, 32'd7, "div", 1'b0);
        drive_now(4'd3, 32'd0, 32'd0, "mfhi_div", 1'b1);
        release_start();

        run_long(4'd8, 32'd5, 32'd0, "div0", 1'b0);
        drive_now(4'd3, 32'd0, 32'd0, "mfhi_div0", 1'b1);
        send(4'd0, 32'hFF, 32'h0F, "and_clear");
        release_start();

        run_long(4'd5, 32'h1234_5678, 32'h9ABC_DEF0, "mult_poke", 1'b1);
        drive_now(4'd3, 32'd0, 32'd0, "mfhi_poke", 1'b1);
        send(4'd4, 32'd0, 32'd0, "mflo_poke");
        send(4'd9, 32'hCAFE_0001, 32'd0, "mthi");
        send(4'd10, 32'hBEEF_0002, 32'd0, "mtlo");
        send(4'd3, 32'd0, 32'd0, "mfhi_mt");
        send(4'd4, 32'd0, 32'd0, "mflo_mt");
        release_start();
        repeat (2) @(negedge clk);

        // Reset mid-divide, with a start presented alongside the reset.
        @(negedge clk);
        drive_now(4'd8, 32'd1000, 32'd3, "div_abort", 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        drive_now(4'd2, 32'd1, 32'd1, "add_in_rst", 1'b0);
        @(posedge clk);
        #1;
        check_eq("midrst_data", {32'b0, dout}, 64'd0);
        check_eq("midrst_done", {63'b0, done}, 64'd0);
        check_eq("midrst_busy", {63'b0, busy}, 64'd0);
        check_eq("midrst_ovf", {63'b0, ovf}, 64'd0);
        check_eq("midrst_div0", {63'b0, div0}, 64'd0);
        mhi = '0; mlo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("postrst_busy", {63'b0, busy}, 64'd0);
        send(4'd3, 32'd0, 32'd0, "mfhi_rst");
        send(4'd4, 32'd0, 32'd0, "mflo_rst");
        release_start();
        repeat (2) @(negedge clk);

        // Narrow instance: 0xFF * 0xFF with 8-cycle latency.
        busy8_n = 0; seen8 = 1'b0;
        start8 = 1'b1; op8 = 4'd5; a8 = 8'hFF; b8 = 8'hFF;
        for (int k = 1; k <= 30 && !seen8; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            if (done8) seen8 = 1'b1;
            else if (busy8) busy8_n++;
        end
        check_eq("w8_seen", {63'b0, seen8}, 64'd1);
        check_eq("w8_busy_cycles", busy8_n, 64'd8);
        check_eq("w8_lo", {56'b0, dout8}, 64'h01);
        start8 = 1'b1; op8 = 4'd3;
        @(negedge clk);
        check_eq("w8_mfhi", {56'b0, dout8}, 64'hFE);
        check_eq("w8_mfhi_done", {63'b0, done8}, 64'd1);
        op8 = 4'd4;
        @(negedge clk);
        check_eq("w8_mflo", {56'b0, dout8}, 64'h01);
        check_eq("w8_ovf", {63'b0, ovf8}, 64'd0);
        check_eq("w8_div0", {63'b0, div08}, 64'd0);
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        check_eq("sb_empty", sb.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
